// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Hardware initiator for the TotalALU command interface. Takes one
//   operation request at a time over a valid/ready port, drives the ALU's
//   Signal/dataA/dataB inputs with registered values, samples the ALU
//   Output a fixed number of cycles later and hands the result back over a
//   valid/ready response port. A DIVU request is expanded into a timed
//   divide, an MFHI and an MFLO, giving two tagged responses (Hi, then Lo).
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   req_valid  : request present
//   req_ready  : block can accept a request (only while idle)
//   req_op     : ALU function code
//   req_a/b    : operands
//   alu_signal : to TotalALU Signal
//   alu_dataA/B: to TotalALU dataA/dataB
//   alu_out    : from TotalALU Output
//   rsp_valid  : response present
//   rsp_ready  : consumer accepts response
//   rsp_data   : result, bit-exact copy of alu_out (0 on error)
//   rsp_tag    : 0 normal, 1 Hi (remainder), 2 Lo (quotient)
//   rsp_err    : request carried an unsupported op

module alu_cmd_issuer #(
  parameter int ALU_LAT  = 2,
  parameter int DIV_WAIT = 35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic        rsp_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_DIVW   = 3'd2;
  localparam logic [2:0] S_MFHI_X = 3'd3;
  localparam logic [2:0] S_RSP_HI = 3'd4;
  localparam logic [2:0] S_MFLO_X = 3'd5;
  localparam logic [2:0] S_RSP    = 3'd6;

  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_ADD  = 6'd32;
  localparam logic [5:0] OP_SUB  = 6'd34;
  localparam logic [5:0] OP_AND  = 6'd36;
  localparam logic [5:0] OP_OR   = 6'd37;
  localparam logic [5:0] OP_SLT  = 6'd42;

  localparam logic [1:0] TAG_NORM = 2'd0;
  localparam logic [1:0] TAG_HI   = 2'd1;
  localparam logic [1:0] TAG_LO   = 2'd2;

  // Counter reload values: the counter is loaded on the edge that enters a
  // timed state and the state is left on the edge where it reads zero, so
  // loading N-1 gives exactly N edges in the state.
  localparam logic [7:0] LAT_LOAD = 8'(ALU_LAT - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_WAIT - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       op_ok;

  // Ops a requester may ask for; MFHI/MFLO are only ever generated here.
  always_comb begin
    op_ok = 1'b0;
    case (req_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL, OP_DIVU: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  // Single registered FSM: every port output is a flop so the ALU sees a
  // clean command for the whole time a state is occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      req_ready  <= 1'b0;
      alu_signal <= 6'd0;
      alu_dataA  <= 32'd0;
      alu_dataB  <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_tag    <= TAG_NORM;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (op_ok) begin
              alu_dataA <= req_a;
              alu_dataB <= req_b;
              if (req_op == OP_DIVU) begin
                alu_signal <= OP_DIVU;
                cnt        <= DIV_LOAD;
                state      <= S_DIVW;
              end else begin
                alu_signal <= req_op;
                cnt        <= LAT_LOAD;
                state      <= S_EXEC;
              end
            end else begin
              // Rejected op: answer straight away, ALU left untouched.
              rsp_valid <= 1'b1;
              rsp_data  <= 32'd0;
              rsp_tag   <= TAG_NORM;
              rsp_err   <= 1'b1;
              state     <= S_RSP;
            end
          end
        end

        S_EXEC: begin
          if (cnt == 8'd0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_tag   <= TAG_NORM;
            rsp_err   <= 1'b0;
            state     <= S_RSP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_DIVW: begin
          if (cnt == 8'd0) begin
            alu_signal <= OP_MFHI;
            cnt        <= LAT_LOAD;
            state      <= S_MFHI_X;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_MFHI_X: begin
          if (cnt == 8'd0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_tag   <= TAG_HI;
            rsp_err   <= 1'b0;
            state     <= S_RSP_HI;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        // Lo is only fetched once Hi has been taken, so the consumer never
        // sees two responses outstanding.
        S_RSP_HI: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            alu_signal <= OP_MFLO;
            cnt        <= LAT_LOAD;
            state      <= S_MFLO_X;
          end
        end

        S_MFLO_X: begin
          if (cnt == 8'd0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_tag   <= TAG_LO;
            rsp_err   <= 1'b0;
            state     <= S_RSP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        // Leaving RSP raises req_ready at once; the next accept therefore
        // lands on the edge after the response handshake at the earliest.
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_tag    <= TAG_NORM;
            rsp_err    <= 1'b0;
            alu_signal <= 6'd0;
            alu_dataA  <= 32'd0;
            alu_dataB  <= 32'd0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b0;
          rsp_valid  <= 1'b0;
          alu_signal <= 6'd0;
          alu_dataA  <= 32'd0;
          alu_dataB  <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Hardware initiator for the TotalALU command interface.
- Accepts operation requests over a valid/ready port and drives the ALU's Signal/dataA/dataB inputs.
- Samples the ALU Output and returns results over a valid/ready response port.
- For DIVU it holds the divide command for the divider run time, then issues MFHI and MFLO automatically and returns Hi and Lo as two tagged responses.
- Sits between a sequencer or CPU decode stage and TotalALU.

Parameters:
- ALU_LAT, 2, cycles from driving a command until alu_out is sampled; legal range 1..15.
- DIV_WAIT, 35, cycles DIVU (6'd27) is held on alu_signal before MFHI is issued; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  6  ALU function code.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_signal  out  6  to TotalALU Signal.
- alu_dataA  out  32  to TotalALU dataA.
- alu_dataB  out  32  to TotalALU dataB.
- alu_out  in  32  from TotalALU Output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  result.
- rsp_tag  out  2  0 = normal result, 1 = Hi (remainder), 2 = Lo (quotient).
- rsp_err  out  1  request had an unsupported op.

Behaviour:
- Supported ops: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, DIVU 27. MFHI 16 and MFLO 18 are generated internally only; requesting them directly is an error.
- States: IDLE, EXEC, DIVW, MFHI_X, RSP_HI, MFLO_X, RSP.
- Reset (reset = 0, asynchronous):
  - state = IDLE; every output = 0, including alu_signal = 6'd0 and rsp_*.
  - Any in-flight operation is dropped; no response is emitted for it.
- IDLE:
  - req_ready = 1; alu_signal/dataA/dataB = 0.
  - Handshake on req_valid & req_ready at edge E0; operands are latched.
  - Supported non-DIVU op -> EXEC.
  - DIVU -> DIVW.
  - Unsupported op -> RSP with rsp_err = 1, rsp_data = 0, rsp_tag = 0; no ALU command is driven.
- req_ready = 0 in every state except IDLE; there is no request pipelining.
- All ALU-side outputs are registered: the value changes right after the edge that enters a state and is held for the whole state.
- EXEC:
  - Drives {op, a, b}.
  - alu_out is captured into rsp_data at edge E0 + ALU_LAT, then -> RSP with tag 0.
  - The ALU command remains driven until RSP is left.
- DIVW:
  - Drives {27, a, b} for exactly DIV_WAIT cycles, counted by an 8-bit down-counter.
  - At edge E0 + DIV_WAIT -> MFHI_X.
- MFHI_X:
  - Drives {16, a, b}.
  - Captures alu_out after ALU_LAT cycles -> RSP_HI (tag 1).
  - alu_signal stays 16 during RSP_HI.
- RSP_HI: rsp_valid = 1 until rsp_ready is sampled high, then -> MFLO_X.
- MFLO_X: drives 18; captures after ALU_LAT cycles -> RSP (tag 2).
- RSP:
  - rsp_valid = 1; rsp_data/tag/err stay stable while rsp_ready = 0.
  - On rsp_ready -> IDLE: rsp_valid drops the next cycle and ALU outputs return to 0.
- A new request is not accepted in the same cycle as a response handshake. The earliest next accept is one cycle after returning to IDLE.
- Latency, acceptance to rsp_valid:
  - Normal op: ALU_LAT.
  - DIVU: DIV_WAIT + ALU_LAT to the Hi response; Lo arrives ALU_LAT cycles after Hi is accepted.
  - Error: 1.
- Arithmetic is done entirely by the ALU. The block performs no width changes, and rsp_data = alu_out bit-exact.
- req_* are ignored when req_ready = 0. rsp_ready is ignored when rsp_valid = 0.

Test Plan:
1. ADD 32, a = 7, b = 5, rsp_ready = 1 -> alu_signal = 32 for ALU_LAT cycles; rsp_valid 2 cycles after accept with rsp_data = 12, tag 0, err 0.
2. SUB 34, a = 3, b = 5 -> rsp_data = 32'hFFFFFFFE. SLT 42, a = 3, b = 5 -> rsp_data = 1.
3. DIVU, a = 100, b = 7 -> alu_signal = 27 for 35 cycles, then 16. Hi response has data 2, tag 1. Then alu_signal = 18, and the Lo response has data 14, tag 2. req_ready = 0 throughout.
4. Backpressure: ADD with rsp_ready held low for 5 cycles -> rsp_valid/rsp_data stable for all 5 cycles, req_ready = 0; accept on cycle 6; req_ready = 1 the following cycle.
5. Unsupported req_op = 9 (and 16) -> rsp_err = 1, rsp_data = 0 one cycle after accept; alu_signal stays 0.
6. Reset asserted 10 cycles into a DIVU -> all outputs 0 immediately, no Hi/Lo responses. After release, ADD 1 + 1 returns 2 normally.

Bench: drive TotalALU or a behavioural ALU model with matching latency.
